// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 rate-1/2 code: generators, trellis state encoding
// and the encoder FSM enum, so the encoder and the decoder BMU agree on branch symbols.
package viterbi_pkg;
  localparam int NUM_STATES = 4;
  localparam int K          = 3;

  localparam logic [K-1:0] G0_DEF = 3'b111;
  localparam logic [K-1:0] G1_DEF = 3'b101;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } trellis_state_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    TAIL = 2'b10
  } enc_fsm_e;

  // Modulo-2 sum of the register taps selected by generator g.
  function automatic logic parity_tap(input logic [K-1:0] v, input logic [K-1:0] g);
    return ^(v & g);
  endfunction
endpackage

// File: rtl/conv_enc_core.sv
// One trellis step: branch symbol and successor state for input bit u from state s.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic         i_u,
  input  logic [K-2:0] i_s,
  output logic [1:0]   o_sym,
  output logic [K-2:0] o_next_s
);
  logic [K-1:0] w_reg;

  assign w_reg    = {i_u, i_s};
  assign o_sym    = {parity_tap(w_reg, G0), parity_tap(w_reg, G1)};
  assign o_next_s = w_reg[K-1:1];
endmodule

// File: rtl/conv_encoder_k3.sv
// Framed rate-1/2 K=3 convolutional encoder with a one-deep output register and
// zero-tail termination so every frame ends the decoder trellis in S0.
module conv_encoder_k3
  import viterbi_pkg::*;
#(
  parameter logic [2:0] G0       = G0_DEF,
  parameter logic [2:0] G1       = G1_DEF,
  parameter int         TAIL_LEN = 2,
  parameter int         CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_bit_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       out_sym_o,
  output logic             out_last_o,
  output logic [1:0]       enc_state_o,
  output logic [CNT_W-1:0] sym_cnt_o,
  output logic             busy_o
);
  localparam int              TC_W      = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam logic [TC_W-1:0] TAIL_LAST = TC_W'(TAIL_LEN - 1);

  generate
    if (TAIL_LEN < 1) begin : g_tail_chk
      $error("conv_encoder_k3: TAIL_LEN must be at least 1");
    end
  endgenerate

  enc_fsm_e         r_fsm, w_fsm_nxt;
  logic [1:0]       r_enc_state;
  logic [1:0]       r_sym;
  logic             r_out_valid;
  logic             r_out_last;
  logic [CNT_W-1:0] r_sym_cnt;
  logic [TC_W-1:0]  r_tail_cnt;

  logic       w_can_load, w_in_fire, w_tail_load, w_load, w_u, w_last_tail;
  logic [1:0] w_sym, w_next_s;

  assign w_can_load  = !r_out_valid || out_ready_i;
  assign in_ready_o  = w_can_load && (r_fsm != TAIL) && !rst_i;
  assign w_in_fire   = in_valid_i && in_ready_o;
  assign w_tail_load = w_can_load && (r_fsm == TAIL);
  assign w_load      = w_in_fire || w_tail_load;
  assign w_u         = w_tail_load ? 1'b0 : in_bit_i;
  assign w_last_tail = w_tail_load && (r_tail_cnt == TAIL_LAST);

  conv_enc_core #(
    .G0(G0),
    .G1(G1)
  ) u_core (
    .i_u     (w_u),
    .i_s     (r_enc_state),
    .o_sym   (w_sym),
    .o_next_s(w_next_s)
  );

  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      IDLE, DATA: if (w_in_fire) w_fsm_nxt = in_last_i ? TAIL : DATA;
      TAIL:       if (w_last_tail) w_fsm_nxt = IDLE;
      default:    w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_fsm <= IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  // Everything below advances only on a load, so backpressure freezes it all.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_enc_state <= 2'b00;
      r_sym       <= 2'b00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_sym_cnt   <= '0;
      r_tail_cnt  <= '0;
    end else begin
      if (w_load) begin
        r_sym       <= w_sym;
        r_out_valid <= 1'b1;
        r_out_last  <= w_last_tail;
        r_enc_state <= w_next_s;
        if (w_in_fire && (r_fsm == IDLE)) r_sym_cnt <= CNT_W'(1);
        else if (r_sym_cnt != '1)         r_sym_cnt <= r_sym_cnt + CNT_W'(1);
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (w_in_fire && in_last_i) r_tail_cnt <= '0;
      else if (w_tail_load)       r_tail_cnt <= r_tail_cnt + TC_W'(1);
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_sym_o   = r_sym;
  assign out_last_o  = r_out_last;
  assign enc_state_o = r_enc_state;
  assign sym_cnt_o   = r_sym_cnt;
  assign busy_o      = (r_fsm != IDLE) || r_out_valid;
endmodule

// File: tb/tb_conv_encoder_k3.sv
// Scoreboard bench: the driver pushes expected symbols computed from the code
// polynomials as shift-register arithmetic; a negedge monitor pops and compares.
module tb_conv_encoder_k3;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i, in_bit_i, in_last_i;
  logic        in_ready_o;
  logic        out_valid_o, out_ready_i, out_last_o, busy_o;
  logic [1:0]  out_sym_o, enc_state_o;
  logic [15:0] sym_cnt_o;

  conv_encoder_k3 dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_bit_i   (in_bit_i),
    .in_last_i  (in_last_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_sym_o  (out_sym_o),
    .out_last_o (out_last_o),
    .enc_state_o(enc_state_o),
    .sym_cnt_o  (sym_cnt_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] sym;
    logic       last;
    int         cnt;
  } exp_t;

  exp_t       sbq[$];
  logic [1:0] obs[$];
  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held by main
  bit b2b_flag;

  // reference: the two previous information bits of the frame
  bit m_p1, m_p2;
  int m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_sym(input bit u, input bit last);
    exp_t e;
    e.sym  = {u ^ m_p1 ^ m_p2, u ^ m_p2};
    e.last = last;
    m_cnt++;
    e.cnt  = m_cnt;
    sbq.push_back(e);
    m_p2 = m_p1;
    m_p1 = u;
  endfunction

  function automatic void model_bit(input bit u, input bit last);
    push_sym(u, 1'b0);
    if (last) begin
      push_sym(1'b0, 1'b0);
      push_sym(1'b0, 1'b1);
      m_cnt = 0;
    end
  endfunction

  function automatic void model_reset();
    m_p1 = 0; m_p2 = 0; m_cnt = 0;
    sbq.delete();
  endfunction

  // monitor
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_sym: got %0d with empty scoreboard at %0t", out_sym_o, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sym", int'(out_sym_o), int'(e.sym));
        chk("last", int'(out_last_o), int'(e.last));
        chk("sym_cnt", int'(sym_cnt_o), e.cnt);
        if (e.last) chk("end_state", int'(enc_state_o), 0);
      end
      obs.push_back(out_sym_o);
    end
  end

  // downstream ready
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #2;
      if (rdy_mode == 0)      out_ready_i = 1'b1;
      else if (rdy_mode == 1) out_ready_i = ($urandom_range(99) < 70);
    end
  end

  task automatic send_bit(input bit u, input bit last, input int gap_pct);
    int tmo;
    tmo = 0;
    while ($urandom_range(99) < gap_pct) begin
      in_valid_i = 1'b0;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b1; in_bit_i = u; in_last_i = last;
    forever begin
      @(negedge clk_i);
      if (in_ready_o) break;
      tmo++;
      if (tmo > 1000) begin
        chk("accept_timeout", tmo, 0);
        in_valid_i = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
    end
    b2b_flag = out_valid_o && out_last_o && out_ready_i;
    model_bit(u, last);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(posedge clk_i); n++;
    end
    #1;
    chk("drain", sbq.size(), 0);
  endtask

  task automatic check_log(input string name, input logic [31:0] exp, input int n);
    chk({name, "_len"}, obs.size(), n);
    for (int i = 0; i < n && i < obs.size(); i++)
      chk(name, int'(obs[i]), int'(exp[2*(n-1-i) +: 2]));
    obs.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, int'(out_valid_o), 0);
    chk({tag, "_sym"},   int'(out_sym_o), 0);
    chk({tag, "_last"},  int'(out_last_o), 0);
    chk({tag, "_cnt"},   int'(sym_cnt_o), 0);
    chk({tag, "_busy"},  int'(busy_o), 0);
    chk({tag, "_ready"}, int'(in_ready_o), 0);
    chk({tag, "_state"}, int'(enc_state_o), 0);
  endtask

  initial begin
    logic [1:0] held;
    rst_i = 1'b1; in_valid_i = 1'b0; in_bit_i = 1'b0; in_last_i = 1'b0;
    model_reset();
    #2;
    chk_reset_vals("rst");
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;

    // frame 1,0,1,1 at full throughput
    send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 1, 0);
    wait_drain();
    check_log("f1011", 32'b11_10_00_01_01_11, 6);
    chk("f1011_state", int'(enc_state_o), 0);
    chk("f1011_cnt", int'(sym_cnt_o), 6);

    // single-bit frame: no input accepted during the two tail loads
    send_bit(1, 1, 0);
    @(negedge clk_i); chk("tail_rdy0", int'(in_ready_o), 0);
    @(negedge clk_i); chk("tail_rdy1", int'(in_ready_o), 0);
    @(negedge clk_i); chk("tail_rdy_end", int'(in_ready_o), 1);
    wait_drain();
    check_log("f1", 32'b11_10_11, 3);

    // three-cycle stall mid-frame with a bit waiting at the input
    send_bit(1, 0, 0); send_bit(0, 0, 0);
    rdy_mode = 2; out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_bit_i = 1'b1; in_last_i = 1'b0;
    held = out_sym_o;
    repeat (3) begin
      @(negedge clk_i);
      chk("stall_rdy", int'(in_ready_o), 0);
      chk("stall_sym", int'(out_sym_o), int'(held));
      chk("stall_valid", int'(out_valid_o), 1);
    end
    rdy_mode = 0;
    send_bit(1, 0, 0); send_bit(1, 1, 0);
    wait_drain();
    check_log("stall", 32'b11_10_00_01_01_11, 6);

    // back-to-back frames with valid held high
    send_bit(1, 1, 0);
    send_bit(1, 0, 0);
    chk("b2b_accept_on_tail", int'(b2b_flag), 1);
    send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 1, 0);
    wait_drain();
    check_log("b2b", 32'b11_10_11_11_10_00_01_01_11, 9);

    // asynchronous reset mid-DATA
    send_bit(1, 0, 0); send_bit(1, 0, 0); send_bit(0, 0, 0);
    #2 rst_i = 1'b1;
    #1 chk_reset_vals("arst");
    model_reset();
    obs.delete();
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    send_bit(1, 0, 0); send_bit(0, 0, 0); send_bit(1, 0, 0); send_bit(1, 1, 0);
    wait_drain();
    check_log("post_rst", 32'b11_10_00_01_01_11, 6);

    // random frames under random valid/ready
    rdy_mode = 1;
    for (int f = 0; f < 20; f++) begin
      int len;
      len = $urandom_range(200, 1);
      for (int i = 0; i < len; i++)
        send_bit(1'($urandom_range(1)), (i == len - 1), 30);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
